bcd_serial_adder_n: RTL and testbench

Parametrised, sequential multi-digit BCD adder/subtractor that processes one decimal digit per clock, least significant digit first. Operands are validated and captured on a start pulse, and the result is presented once complete. The result drives the board's seven-segment displays: one digit per display, plus one display for the carry. This block is the multi-digit, clocked successor of the two-digit combinational BCD adder used in the switch/LED/HEX lab designs.

---
 rtl/bcd_serial_adder_n.sv | 161 ++++++++++++++++
 tb/tb_bcd_serial_adder_n.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder_n.sv
// Sequential multi-digit BCD adder/subtractor: one decimal digit per clock, LSD first,
// with validated operand capture and active-low seven-segment output per result digit.
module bcd_serial_adder_n #(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic                      cin,
  input  logic [4*DIGITS-1:0]       x,
  input  logic [4*DIGITS-1:0]       y,
  output logic [4*DIGITS-1:0]       sum,
  output logic                      cout,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [7*(DIGITS+1)-1:0]   hex
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state_reg;
  logic [W-1:0]    xa_reg;
  logic [W-1:0]    yb_reg;
  logic [W-1:0]    work_reg;
  logic [W-1:0]    work_next;
  logic [W-1:0]    y_cond;
  logic            carry_reg;
  logic            carry_next;
  logic [IW-1:0]   idx_reg;
  logic            bad_digit;
  logic [4:0]      t;
  logic [4:0]      t_adj;
  logic [3:0]      dig;
  logic            last_digit;

  // Validate raw operands and nine's-complement y for subtraction at capture time
  always_comb begin
    bad_digit = 1'b0;
    y_cond    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (x[4*k +: 4] > 4'd9 || y[4*k +: 4] > 4'd9)
        bad_digit = 1'b1;
      y_cond[4*k +: 4] = sub ? (4'd9 - y[4*k +: 4]) : y[4*k +: 4];
    end
  end

  // Operand registers shift right each cycle, so the current digit always sits at [3:0]
  always_comb begin
    t     = {1'b0, xa_reg[3:0]} + {1'b0, yb_reg[3:0]} + {4'b0000, carry_reg};
    t_adj = t - 5'd10;
    if (t > 5'd9) begin
      dig        = t_adj[3:0];
      carry_next = 1'b1;
    end else begin
      dig        = t[3:0];
      carry_next = 1'b0;
    end
  end

  always_comb begin
    work_next = work_reg;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_reg == IW'(k))
        work_next[4*k +: 4] = dig;
    end
  end

  assign last_digit = (idx_reg == IW'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      xa_reg    <= '0;
      yb_reg    <= '0;
      work_reg  <= '0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            xa_reg    <= x;
            yb_reg    <= y_cond;
            carry_reg <= sub | cin;
            idx_reg   <= '0;
            work_reg  <= '0;
            if (bad_digit) begin
              sum       <= '0;
              cout      <= 1'b0;
              err       <= 1'b1;
              done      <= 1'b1;
              state_reg <= FIN;
            end else begin
              busy      <= 1'b1;
              state_reg <= RUN;
            end
          end
        end
        RUN: begin
          work_reg  <= work_next;
          carry_reg <= carry_next;
          xa_reg    <= xa_reg >> 4;
          yb_reg    <= yb_reg >> 4;
          idx_reg   <= idx_reg + 1'b1;
          if (last_digit) begin
            // Results are loaded on entry to FIN so they are visible during the done cycle
            sum       <= work_next;
            cout      <= carry_next;
            err       <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            idx_reg   <= '0;
            state_reg <= FIN;
          end
        end
        FIN: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_hex
      assign hex[7*gi +: 7] = err ? 7'b1111111 : seg7(sum[4*gi +: 4]);
    end
  endgenerate

  assign hex[7*DIGITS +: 7] = err ? 7'b1111111 : seg7({3'b000, cout});

endmodule

// File: tb/tb_bcd_serial_adder_n.sv
// Directed scoreboard bench for bcd_serial_adder_n (DIGITS=4 main instance, DIGITS=1 side instance).
module tb_bcd_serial_adder_n;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0]   x = '0, y = '0;
  logic [15:0]   sum;
  logic          cout, busy, done, err;
  logic [34:0]   hex;

  logic          start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [3:0]    x1 = '0, y1 = '0;
  logic [3:0]    sum1;
  logic          cout1, busy1, done1, err1;
  logic [13:0]   hex1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        e;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_serial_adder_n #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
    .x(x), .y(y), .sum(sum), .cout(cout), .busy(busy), .done(done),
    .err(err), .hex(hex)
  );

  bcd_serial_adder_n #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .cin(cin1),
    .x(x1), .y(y1), .sum(sum1), .cout(cout1), .busy(busy1), .done(done1),
    .err(err1), .hex(hex1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad(input logic [15:0] v);
    bit b = 0;
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) b = 1;
    return b;
  endfunction

  function automatic logic [6:0] pat(input int d);
    logic [6:0] lut [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return lut[d];
  endfunction

  function automatic logic [34:0] exp_hex(input logic [15:0] s, input logic c, input logic e);
    logic [34:0] h;
    for (int i = 0; i < 4; i++) h[7*i +: 7] = e ? 7'h7F : pat(int'(s[4*i +: 4]));
    h[28 +: 7] = e ? 7'h7F : pat(c ? 1 : 0);
    return h;
  endfunction

  // Called at a negedge: drives a start for the current cycle and records the expected result
  task automatic launch(input logic [15:0] ax, input logic [15:0] ay, input logic asub, input logic acin);
    exp_t ex;
    int total;
    ex.e = has_bad(ax) || has_bad(ay);
    if (ex.e) begin
      ex.s = '0;
      ex.c = 1'b0;
    end else begin
      if (asub) total = bcd2int(ax) + 10000 - bcd2int(ay);
      else      total = bcd2int(ax) + bcd2int(ay) + (acin ? 1 : 0);
      ex.c = (total >= 10000);
      ex.s = int2bcd(total % 10000);
    end
    sb.push_back(ex);
    x = ax; y = ay; sub = asub; cin = acin; start = 1'b1;
  endtask

  // Counts cycles from the launch, optionally injects a rival start, then checks the result
  task automatic wait_result(input string tag, input int inject_cycle,
                             input logic [15:0] ix, input logic [15:0] iy);
    exp_t ex;
    int n;
    int lat;
    ex = sb[0];
    lat = ex.e ? 1 : D + 1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 20) begin
      if (done) break;
      check({tag, "_busy"}, busy, (n <= D) && !ex.e);
      if (n == inject_cycle) begin
        x = ix; y = iy; sub = ~sub; cin = ~cin; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, lat);
    ex = sb.pop_front();
    check({tag, "_sum"}, sum, ex.s);
    check({tag, "_cout"}, cout, ex.c);
    check({tag, "_err"}, err, ex.e);
    check({tag, "_busy_fin"}, busy, 1'b0);
    check({tag, "_hex"}, hex, exp_hex(ex.s, ex.c, ex.e));
    $display("txn %s: sum=%h cout=%0d err=%0d latency=%0d", tag, sum, cout, err, n);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_sum"}, sum, 16'h0000);
    check({tag, "_cout"}, cout, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_hex"}, hex, exp_hex(16'h0000, 1'b0, 1'b0));
  endtask

  initial begin
    int seen;
    int n;
    logic [3:0] ax1 [2] = '{4'd9, 4'd3};
    logic [3:0] ay1 [2] = '{4'd9, 4'd4};
    logic       as1 [2] = '{1'b0, 1'b1};
    logic [3:0] es1 [2] = '{4'd9, 4'd9};
    logic       ec1 [2] = '{1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    launch(16'h1234, 16'h5678, 1'b0, 1'b0);
    wait_result("add_1234_5678", -1, 16'h0, 16'h0);
    launch(16'h9999, 16'h0001, 1'b0, 1'b1);
    wait_result("ripple_9999_0001", -1, 16'h0, 16'h0);
    launch(16'h9999, 16'h9999, 1'b0, 1'b1);
    wait_result("max_9999_9999_c1", -1, 16'h0, 16'h0);
    launch(16'h5000, 16'h1234, 1'b1, 1'b1);
    wait_result("sub_5000_1234", -1, 16'h0, 16'h0);
    launch(16'h1234, 16'h5000, 1'b1, 1'b1);
    wait_result("sub_1234_5000", -1, 16'h0, 16'h0);
    launch(16'h0000, 16'h0000, 1'b1, 1'b0);
    wait_result("sub_0000_0000", -1, 16'h0, 16'h0);
    launch(16'h12A4, 16'h0000, 1'b0, 1'b0);
    wait_result("invalid_x", -1, 16'h0, 16'h0);
    launch(16'h0042, 16'h00F0, 1'b1, 1'b0);
    wait_result("invalid_y", -1, 16'h0, 16'h0);
    launch(16'h0808, 16'h0191, 1'b0, 1'b0);
    wait_result("clear_err", -1, 16'h0, 16'h0);

    // A second start during RUN (with flipped sub/cin) must be ignored; next op follows immediately
    launch(16'h4321, 16'h1111, 1'b0, 1'b0);
    wait_result("busy_ignore", 2, 16'h9999, 16'h9999);
    launch(16'h0505, 16'h0505, 1'b0, 1'b1);
    wait_result("back_to_back", -1, 16'h0, 16'h0);

    // Reset during RUN: no done pulse, outputs back to reset values
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    void'(sb.pop_front());
    check_reset("reset_mid_run");
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("reset_no_done", seen, 0);
    launch(16'h2468, 16'h1357, 1'b0, 1'b0);
    wait_result("after_reset", -1, 16'h0, 16'h0);

    // Single-digit instance: two-cycle latency
    for (int k = 0; k < 2; k++) begin
      x1 = ax1[k]; y1 = ay1[k]; sub1 = as1[k]; cin1 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 1;
      while (n < 10 && !done1) begin
        @(negedge clk);
        n++;
      end
      check("d1_latency", n, 2);
      check("d1_sum", sum1, es1[k]);
      check("d1_cout", cout1, ec1[k]);
      $display("txn d1_%0d: sum=%h cout=%0d latency=%0d", k, sum1, cout1, n);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
